iter_sequencer: RTL

ITER_SEQUENCER -- requirements
Module: iter_sequencer

---
 rtl/iter_sequencer_pkg.sv | 16 +
 rtl/iter_sequencer_if.sv | 27 ++
 rtl/iter_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/iter_sequencer_pkg.sv
// Shared types and state encoding for the iteration sequencer.
package iter_seq_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ENC_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ENC_FIN  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = ENC_IDLE,
        RUN  = ENC_RUN,
        FIN  = ENC_FIN
    } state_t;

endpackage

// File: rtl/iter_sequencer_if.sv
// Control/status bundle between a sequence requester and the iteration sequencer.
interface iter_sequencer_if #(
    parameter int unsigned WIDTH = 6
) ();

    logic             start;
    logic [WIDTH-1:0] len;
    logic             en;
    logic             abort;
    logic             busy;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] idx;
    logic             done;
    logic             aborted;

    modport master (
        output start, len, en, abort,
        input  busy, step, last, idx, done, aborted
    );

    modport slave (
        input  start, len, en, abort,
        output busy, step, last, idx, done, aborted
    );

endinterface

// File: rtl/iter_sequencer.sv
// Iteration sequencer: issues len_q gated step strobes per pass, one-shot or auto-reload.
module iter_sequencer
    import iter_seq_pkg::*;
#(
    parameter int unsigned WIDTH       = 6,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    iter_sequencer_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic             step_c;
    logic             at_last_c;

    // State, counter and pulse registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state, counter update and completion/abort pulse decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        step_c    = (state_q == RUN) & bus.en & ~bus.abort;
        at_last_c = (idx_q == (len_q - WIDTH'(1)));

        unique case (state_q)
            IDLE, FIN: begin
                // FIN is a single-cycle stop; both accept a new start.
                state_d = IDLE;
                if (bus.start) begin
                    if (bus.len != '0) begin
                        state_d = RUN;
                        len_d   = bus.len;
                        idx_d   = '0;
                    end else begin
                        // Empty request completes immediately with no steps.
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    aborted_d = 1'b1;
                end else if (bus.en) begin
                    if (at_last_c) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = AUTO_RELOAD ? RUN : FIN;
                    end else begin
                        idx_d = idx_q + WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.step    = step_c;
    assign bus.last    = step_c & at_last_c;
    assign bus.idx     = idx_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;

endmodule
